fp_accumulator: RTL and testbench
=================================

Name: fp_accumulator

Overview:
- Downstream neighbour of the FP multiplier in the conv/FC datapath.
- Consumes a stream of FP products and sums them, starting from a bias value, into one FP result (one neuron / output pixel).
- Number formats and simplifications match the multiplier:
  - IEEE-like {sign, exponent, mantissa} fields, hidden 1.
  - No subnormals, Inf or NaN; truncation, no rounding.
- Handshaked on both the input stream and the result.

Parameters:
- N, 32, total word width (16/32/64).
- E, 8, exponent width (5/8/11).
- M, 23, mantissa width (10/23/52).
- LEN_W, 8, width of term count; max 2**LEN_W-1 products per operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an operation; honoured only in IDLE.
- len  in  LEN_W  number of products to accumulate; sampled with start.
- bias  in  N  initial accumulator value; sampled with start.
- in_valid  in  1  product beat valid.
- in_ready  out  1  accumulator can accept a product this cycle.
- in_data  in  N  FP product (multiplier output).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  N  accumulated FP result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, acc=0, cnt=0.
  - in_ready=0, out_valid=0, out_data=0, busy=0.
  - Asserting reset mid-operation discards all partial sums; no result is produced.
- FSM states: IDLE, ACCUM, DONE.
- IDLE, on start:
  - acc<=bias, cnt<=len.
  - Next state is DONE if len==0, else ACCUM.
- ACCUM:
  - in_ready=1.
  - A beat transfers when in_valid&&in_ready: acc<=fp_add(acc,in_data), cnt<=cnt-1.
  - If cnt==1 at the transfer, next state is DONE.
  - Idle cycles (in_valid=0) leave acc and cnt unchanged.
- DONE:
  - out_valid=1, out_data=acc, in_ready=0.
  - On out_ready, return to IDLE; out_valid drops the next cycle.
  - out_data is held stable while out_valid=1 and out_ready=0.
- start outside IDLE is ignored; start in the same cycle as the DONE->IDLE transfer is ignored.
- Latency: out_valid rises on the cycle after the last accepted beat; for len==0, on the cycle after start.
- Throughput: one product per cycle in ACCUM.
- fp_add rules (combinational):
  - Zero: an operand is zero when bits [N-2:0]==0. If one operand is zero, return the other. If both are zero, return all zeros.
  - Ordering: the larger-magnitude operand L is chosen by comparing exponent, then mantissa; S is the other operand.
  - Alignment: S significand {1,mant} is shifted right by expL-expS and truncated. If the shift is greater than M+1, S contributes 0.
  - Same sign: add. On carry-out, shift right 1 (truncate) and expL+1.
  - Opposite sign: subtract. A zero result gives all-zero output (+0). Otherwise normalise left by the leading-zero count lz and exp=expL-lz; if lz>=expL, flush to all zeros.
  - Result sign is the sign of L.
  - Exponent overflow wraps modulo 2**E; no saturation, consistent with the multiplier.

Decomposition:
- fp_pkg holds:
  - format constants N, E, M and BIAS=2**(E-1)-1;
  - field-extract helpers (sign/exp/mant);
  - the FSM state enum {IDLE, ACCUM, DONE}.
- Sub-module fp_adder (combinational, parameters N/E/M, ports a, b, sum) implements fp_add. It is reusable for the later bias/activation stage.
- fp_accumulator holds only the FSM, acc, cnt and handshakes.

Test Plan:
- bias=0x00000000, len=3, beats 0x3F800000, 0x40000000, 0x40400000 back-to-back -> out_data=0x40C00000 (6.0); out_valid rises the cycle after the 3rd beat; in_ready=0 while out_valid=1.
- bias=0x3FC00000, len=0 -> next cycle out_valid=1, out_data=0x3FC00000; no beat accepted.
- bias=0x3F800000, len=1, beat 0xBF800000 -> out_data=0x00000000 (exact cancellation).
- bias=0x3F800000, len=1, beat 0x30800000 (2^-30) -> out_data=0x3F800000 (truncated alignment).
- len=2 with in_valid gaps, and out_ready held low 3 cycles -> same sum as gapless; out_data stable while stalled; start pulses during busy ignored.
- Reset mid-operation and restart:
  - bias=0x3F800000, len=4; after 2 beats drive rst_n=0 -> all outputs 0 immediately, busy=0, state IDLE.
  - Then bias=0x3F000000, len=1, beat 0x3F000000 -> out_data=0x3F800000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP format constants, field helpers and accumulator FSM states for the
// conv/FC datapath (IEEE-like layout, hidden 1, no subnormals/Inf/NaN).
package fp_pkg;

  localparam int FP_N    = 32;
  localparam int FP_E    = 8;
  localparam int FP_M    = 23;
  localparam int FP_BIAS = (2 ** (FP_E - 1)) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic fp_sign(input logic [FP_N-1:0] w);
    return w[FP_N-1];
  endfunction

  function automatic logic [FP_E-1:0] fp_exp(input logic [FP_N-1:0] w);
    return w[FP_N-2:FP_M];
  endfunction

  function automatic logic [FP_M-1:0] fp_mant(input logic [FP_N-1:0] w);
    return w[FP_M-1:0];
  endfunction

endpackage

// File: rtl/fp_adder.sv
// Combinational truncating FP adder: align smaller operand, add or subtract,
// renormalise. Exponent overflow wraps, underflow flushes to +0.
module fp_adder
  import fp_pkg::*;
#(
  parameter int N = FP_N,
  parameter int E = FP_E,
  parameter int M = FP_M
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  logic          a_zero_s;
  logic          b_zero_s;
  logic          a_big_s;
  logic [N-1:0]  l_s;
  logic [N-1:0]  s_s;
  logic [E-1:0]  exp_l_s;
  logic [E-1:0]  exp_s_s;
  logic [M:0]    sig_l_s;
  logic [M:0]    sig_s_s;
  logic [M:0]    sig_sh_s;
  logic [M:0]    diff_s;
  logic [M:0]    norm_s;
  logic [M+1:0]  add_s;
  logic [31:0]   shamt_s;
  logic [31:0]   lz_s;
  logic [N-1:0]  res_s;

  // Order operands by magnitude and align the smaller one.
  always_comb begin
    a_zero_s = (a[N-2:0] == {(N-1){1'b0}});
    b_zero_s = (b[N-2:0] == {(N-1){1'b0}});
    // {exp, mant} compared as one unsigned field orders by exponent then mantissa
    a_big_s  = (a[N-2:0] >= b[N-2:0]);
    l_s      = a_big_s ? a : b;
    s_s      = a_big_s ? b : a;
    exp_l_s  = l_s[N-2:M];
    exp_s_s  = s_s[N-2:M];
    sig_l_s  = {1'b1, l_s[M-1:0]};
    sig_s_s  = {1'b1, s_s[M-1:0]};
    shamt_s  = {{(32-E){1'b0}}, exp_l_s} - {{(32-E){1'b0}}, exp_s_s};
    if (shamt_s > 32'(M + 1)) begin
      sig_sh_s = {(M+1){1'b0}};
    end else begin
      sig_sh_s = sig_s_s >> shamt_s;
    end
    add_s  = {1'b0, sig_l_s} + {1'b0, sig_sh_s};
    diff_s = sig_l_s - sig_sh_s;
  end

  // Leading-zero count of the difference; the highest set bit wins.
  always_comb begin
    lz_s = 32'(M + 1);
    for (int i = 0; i <= M; i++) begin
      if (diff_s[i]) begin
        lz_s = 32'(M - i);
      end else begin
        lz_s = lz_s;
      end
    end
    norm_s = diff_s << lz_s;
  end

  // Select the final result according to the zero / sign cases.
  always_comb begin
    res_s = {N{1'b0}};
    if (a_zero_s && b_zero_s) begin
      res_s = {N{1'b0}};
    end else if (a_zero_s) begin
      res_s = b;
    end else if (b_zero_s) begin
      res_s = a;
    end else if (a[N-1] == b[N-1]) begin
      if (add_s[M+1]) begin
        res_s = {l_s[N-1], exp_l_s + {{(E-1){1'b0}}, 1'b1}, add_s[M:1]};
      end else begin
        res_s = {l_s[N-1], exp_l_s, add_s[M-1:0]};
      end
    end else if (diff_s == {(M+1){1'b0}}) begin
      res_s = {N{1'b0}};
    end else if (lz_s >= {{(32-E){1'b0}}, exp_l_s}) begin
      res_s = {N{1'b0}};
    end else begin
      res_s = {l_s[N-1], exp_l_s - lz_s[E-1:0], norm_s[M-1:0]};
    end
  end

  assign sum = res_s;

endmodule

// File: rtl/fp_accumulator.sv
// Handshaked FP accumulator: sums len products onto a bias value and presents
// one result per operation.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int N     = FP_N,
  parameter int E     = FP_E,
  parameter int M     = FP_M,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [N-1:0]     bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [N-1:0]     add_sum_s;

  fp_adder #(.N(N), .E(E), .M(M)) u_adder (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum_s)
  );

  // Next-state, accumulator and term-count update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias;
          cnt_d   = len;
          state_d = (len == {LEN_W{1'b0}}) ? DONE : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = add_sum_s;
          cnt_d = cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
          if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        // start in the hand-off cycle is dropped because we only decode it in IDLE
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= {N{1'b0}};
      cnt_q       <= {LEN_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == ACCUM);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator with hand-computed IEEE single results.
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] held;

  fp_accumulator #(.N(32), .E(8), .M(23), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] b, input logic [7:0] l);
    bias  = b;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'd0; bias = 32'd0;
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    #12;
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0 + 1 + 2 + 3 = 6, back-to-back beats
    start_op(32'h0000_0000, 8'd3);
    chk("t1_ready", {30'd0, in_ready, busy}, 32'd3);
    beat(32'h3F80_0000);
    beat(32'h4000_0000);
    chk("t1_not_yet", {31'd0, out_valid}, 32'd0);
    beat(32'h4040_0000);
    chk("t1_latency", {31'd0, out_valid}, 32'd1);
    chk("t1_data", out_data, 32'h40C0_0000);
    chk("t1_ready_low", {31'd0, in_ready}, 32'd0);
    accept("t1");

    // len==0 returns bias the cycle after start
    start_op(32'h3FC0_0000, 8'd0);
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_data", out_data, 32'h3FC0_0000);
    chk("t2_no_ready", {31'd0, in_ready}, 32'd0);
    accept("t2");

    // 1 + -1 cancels to +0
    start_op(32'h3F80_0000, 8'd1);
    beat(32'hBF80_0000);
    wait_result("t3");
    chk("t3_data", out_data, 32'h0000_0000);
    accept("t3");

    // 1 + 2^-30 truncates away
    start_op(32'h3F80_0000, 8'd1);
    beat(32'h3080_0000);
    wait_result("t4");
    chk("t4_data", out_data, 32'h3F80_0000);
    accept("t4");

    // 3 + -2 = 1 needs left renormalisation
    start_op(32'h4040_0000, 8'd1);
    beat(32'hC000_0000);
    wait_result("t5");
    chk("t5_data", out_data, 32'h3F80_0000);
    accept("t5");

    // 1 + -3 = -2, sign of the larger operand
    start_op(32'h3F80_0000, 8'd1);
    beat(32'hC040_0000);
    wait_result("t6");
    chk("t6_data", out_data, 32'hC000_0000);
    accept("t6");

    // 2 + 1 + 0.5 = 3.5 with gaps, busy start pulses and a stalled consumer
    start_op(32'h4000_0000, 8'd2);
    @(negedge clk);
    @(negedge clk);
    beat(32'h3F80_0000);
    start_op(32'h0000_0000, 8'd0);
    chk("t7_start_ignored", {30'd0, in_ready, out_valid}, 32'd2);
    @(negedge clk);
    beat(32'h3F00_0000);
    chk("t7_valid", {31'd0, out_valid}, 32'd1);
    chk("t7_data", out_data, 32'h4060_0000);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t7_stall_hold", out_data, held);
      chk("t7_stall_valid", {31'd0, out_valid}, 32'd1);
    end
    start_op(32'h3F80_0000, 8'd0);
    chk("t7_done_start_ign", out_data, 32'h4060_0000);
    start = 1'b1; bias = 32'h3F80_0000; len = 8'd0;
    accept("t7");
    start = 1'b0;
    @(negedge clk);
    chk("t7_handoff_start_ign", {30'd0, busy, out_valid}, 32'd0);

    // reset mid-operation, then restart: 0.5 + 0.5 = 1
    start_op(32'h3F80_0000, 8'd4);
    beat(32'h3F80_0000);
    beat(32'h3F80_0000);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_data", out_data, 32'h0);
    chk("t8_rst_flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t8_still_idle", {30'd0, busy, out_valid}, 32'd0);
    start_op(32'h3F00_0000, 8'd1);
    beat(32'h3F00_0000);
    wait_result("t8");
    chk("t8_data", out_data, 32'h3F80_0000);
    accept("t8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
